ibex_cx_responder: RTL and testbench

Fabric-side end of the custom-instruction (CX) interface between the core's execute stage and the embedded FPGA. Accepts one CX request at a time: operation type plus two 32-bit operands. Launches it into the fabric, waits either a fixed latency or for a fabric done strobe, then returns the result to the core as a single-cycle response valid pulse. The core's execute stage stalls on that pulse, so the response has no back-pressure.

---
 rtl/ibex_cx_pkg.sv | 33 +++
 rtl/ibex_cx_timeout.sv | 39 +++
 rtl/ibex_cx_responder.sv | 162 ++++++++++++++++
 tb/tb_ibex_cx_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_cx_pkg.sv
// ibex_cx_pkg: shared definitions for the custom-instruction (CX) responder.
// Holds the responder FSM state type and the CX field widths used by the
// responder and its timeout counter.
package ibex_cx_pkg;

   // Width of the CX operation-type field.
   localparam int unsigned CX_OPTYPE_W = 2;
   // Width of the fixed-latency field; zero selects done-strobe completion.
   localparam int unsigned CX_DELAY_W  = 4;
   // Width of operands and results.
   localparam int unsigned CX_DATA_W   = 32;

   // Responder FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } cx_state_e;

   // Latched request fields, captured on acceptance.
   typedef struct packed {
      logic [CX_OPTYPE_W-1:0] optype;
      logic [CX_DATA_W-1:0]   operand_a;
      logic [CX_DATA_W-1:0]   operand_b;
      logic [CX_DELAY_W-1:0]  delay;
   } cx_req_t;

   // True when a latched delay selects fixed-latency completion.
   function automatic logic cx_is_fixed(input logic [CX_DELAY_W-1:0] delay);
      return (delay != '0);
   endfunction

endpackage

// File: rtl/ibex_cx_timeout.sv
// ibex_cx_timeout: loadable down-counter with an expiry flag.
// Loaded with a start value, it decrements once per enabled cycle and stops
// at zero; expired_o is high whenever the count is zero.
module ibex_cx_timeout #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             en_i,
   output logic             expired_o
);

   logic [Width-1:0] count_q;
   logic [Width-1:0] count_d;

   // Next count: load has priority, otherwise decrement and saturate at zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = (count_q == '0);

endmodule

// File: rtl/ibex_cx_responder.sv
// ibex_cx_responder: fabric-side end of the CX interface.
// Accepts one request at a time, launches it into the fabric, completes after
// a fixed latency or on the fabric done strobe, and returns a one-cycle
// response pulse with no back-pressure.
// Optional feature: define CX_TIMEOUT_EN to abort a BUSY operation after
// TimeoutCycles cycles with an error response. Without it the responder waits
// indefinitely and cx_resp_err_o / fab_abort_o stay 0.
//
// Handshake: a request transfers on a clock edge where cx_req_valid_i and
// cx_req_ready_o are both high; ready is high only in IDLE, and a request
// offered in BUSY/RESP must be held by the core until then. The response has
// no ready: cx_resp_valid_o is a single-cycle strobe the core must take.
module ibex_cx_responder
   import ibex_cx_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cx_req_valid_i,
   output logic                   cx_req_ready_o,
   input  logic [CX_OPTYPE_W-1:0] cx_optype_i,
   input  logic [CX_DATA_W-1:0]   cx_operand_a_i,
   input  logic [CX_DATA_W-1:0]   cx_operand_b_i,
   input  logic [CX_DELAY_W-1:0]  cx_delay_i,
   output logic                   cx_resp_valid_o,
   output logic [CX_DATA_W-1:0]   cx_resp_data_o,
   output logic                   cx_resp_err_o,
   output logic                   fab_start_o,
   output logic [CX_OPTYPE_W-1:0] fab_optype_o,
   output logic [CX_DATA_W-1:0]   fab_operand_a_o,
   output logic [CX_DATA_W-1:0]   fab_operand_b_o,
   input  logic [CX_DATA_W-1:0]   fab_result_i,
   input  logic                   fab_done_i,
   output logic                   fab_abort_o
);

   // A timeout shorter than this would race ordinary fixed-latency requests.
   if (TimeoutCycles < 16) begin : g_cfg_check
      $error("ibex_cx_responder: TimeoutCycles must be at least 16");
   end

   cx_state_e              state_q;
   cx_req_t                req_q;
   logic [CX_DELAY_W-1:0]  delay_cnt_q;
   logic                   fab_start_q;
   logic                   resp_valid_q;
   logic [CX_DATA_W-1:0]   resp_data_q;
   logic                   resp_err_q;
   logic                   abort_q;

   logic                   accept;
   logic                   done_now;
   logic                   timeout_now;

   assign accept = (state_q == IDLE) && cx_req_valid_i;

   // Fixed latency finishes when the down-counter reaches 1; a zero latency
   // finishes on the first BUSY cycle that sees the fabric done strobe.
   assign done_now = cx_is_fixed(req_q.delay) ? (delay_cnt_q == CX_DELAY_W'(1))
                                              : fab_done_i;

`ifdef CX_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TimeoutCycles) + 1;

   logic timer_expired;

   // Loaded on acceptance so that it reaches zero in the TimeoutCycles-th
   // BUSY cycle, counting the start cycle as the first.
   ibex_cx_timeout #(
      .Width (TmoW)
   ) u_timeout (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (accept),
      .load_val_i (TmoW'(TimeoutCycles - 1)),
      .en_i       (state_q == BUSY),
      .expired_o  (timer_expired)
   );

   assign timeout_now = timer_expired;
`else
   assign timeout_now = 1'b0;
`endif

   // Responder FSM with all request, fabric and response outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         req_q        <= '0;
         delay_cnt_q  <= '0;
         fab_start_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         // Strobes are high for one cycle unless re-asserted below.
         fab_start_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         abort_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cx_req_valid_i) begin
                  req_q.optype    <= cx_optype_i;
                  req_q.operand_a <= cx_operand_a_i;
                  req_q.operand_b <= cx_operand_b_i;
                  req_q.delay     <= cx_delay_i;
                  delay_cnt_q     <= cx_delay_i;
                  fab_start_q     <= 1'b1;
                  state_q         <= BUSY;
               end
            end
            BUSY: begin
               if (cx_is_fixed(req_q.delay)) begin
                  delay_cnt_q <= delay_cnt_q - 1'b1;
               end
               // Completion takes priority over a coincident timeout.
               if (done_now) begin
                  resp_data_q  <= fab_result_i;
                  resp_err_q   <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end else if (timeout_now) begin
                  resp_data_q  <= '0;
                  resp_err_q   <= 1'b1;
                  resp_valid_q <= 1'b1;
                  abort_q      <= 1'b1;
                  state_q      <= RESP;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cx_req_ready_o  = (state_q == IDLE);
   assign cx_resp_valid_o = resp_valid_q;
   assign cx_resp_data_o  = resp_data_q;
   assign fab_start_o     = fab_start_q;
   assign fab_optype_o    = req_q.optype;
   assign fab_operand_a_o = req_q.operand_a;
   assign fab_operand_b_o = req_q.operand_b;

`ifdef CX_TIMEOUT_EN
   assign cx_resp_err_o   = resp_err_q;
   assign fab_abort_o     = abort_q;
`else
   assign cx_resp_err_o   = 1'b0;
   assign fab_abort_o     = 1'b0;

   // Error and abort registers have no timeout source in this build.
   logic unused_tmo;
   assign unused_tmo = resp_err_q ^ abort_q;
`endif

endmodule

// File: tb/tb_ibex_cx_responder.sv
// tb_ibex_cx_responder: table-driven bench for ibex_cx_responder with a
// response scoreboard. Honours CX_TIMEOUT_EN the same way as the design.
module tb_ibex_cx_responder;

   localparam int TMO = 16;

   logic        clk;
   logic        rst_n;
   logic        cx_req_valid_i;
   logic        cx_req_ready_o;
   logic [1:0]  cx_optype_i;
   logic [31:0] cx_operand_a_i;
   logic [31:0] cx_operand_b_i;
   logic [3:0]  cx_delay_i;
   logic        cx_resp_valid_o;
   logic [31:0] cx_resp_data_o;
   logic        cx_resp_err_o;
   logic        fab_start_o;
   logic [1:0]  fab_optype_o;
   logic [31:0] fab_operand_a_o;
   logic [31:0] fab_operand_b_o;
   logic [31:0] fab_result_i;
   logic        fab_done_i;
   logic        fab_abort_o;

   ibex_cx_responder #(
      .TimeoutCycles (TMO)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cx_req_valid_i  (cx_req_valid_i),
      .cx_req_ready_o  (cx_req_ready_o),
      .cx_optype_i     (cx_optype_i),
      .cx_operand_a_i  (cx_operand_a_i),
      .cx_operand_b_i  (cx_operand_b_i),
      .cx_delay_i      (cx_delay_i),
      .cx_resp_valid_o (cx_resp_valid_o),
      .cx_resp_data_o  (cx_resp_data_o),
      .cx_resp_err_o   (cx_resp_err_o),
      .fab_start_o     (fab_start_o),
      .fab_optype_o    (fab_optype_o),
      .fab_operand_a_o (fab_operand_a_o),
      .fab_operand_b_o (fab_operand_b_o),
      .fab_result_i    (fab_result_i),
      .fab_done_i      (fab_done_i),
      .fab_abort_o     (fab_abort_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // ---------------- scoreboard ----------------
   // Entry: {err, data[31:0], absolute response cycle[15:0]}
   localparam int W = 49;
   logic [W-1:0] exp_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int last_wait = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc_cnt);
      end
   endtask

   // Response monitor: every response pulse must match the oldest expectation.
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (rst_n && cx_resp_valid_o) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_resp: got data 0x%08h err %0b, expected no response (cycle %0d)",
                     cx_resp_data_o, cx_resp_err_o, cyc_cnt);
         end else begin
            e = exp_q.pop_front();
            chk("resp_data", cx_resp_data_o, e[47:16]);
            chk("resp_err", {31'd0, cx_resp_err_o}, {31'd0, e[48]});
            chk("resp_abort", {31'd0, fab_abort_o}, {31'd0, e[48]});
            chk("resp_cycle", 32'(cyc_cnt[15:0]), {16'd0, e[15:0]});
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Offer a request at a negedge and wait until it will be accepted at the
   // next posedge. Returns the cycle count at that negedge.
   task automatic offer(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] d, output int acc);
      int guard;
      @(negedge clk);
      cx_req_valid_i = 1'b1;
      cx_optype_i    = op;
      cx_operand_a_i = a;
      cx_operand_b_i = b;
      cx_delay_i     = d;
      guard = 0;
      while (!cx_req_ready_o && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) chk("accept_timeout", 32'd0, 32'd1);
      last_wait = guard;
      acc = cyc_cnt;
   endtask

   // Full request: the fabric result is valid only in the completion cycle.
   task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] d, input logic [31:0] res, input int k,
                          input bit tog, input bit hold,
                          input logic [31:0] exp_data, input int exp_lat);
      int acc;
      int comp;
      offer(op, a, b, d, acc);
      comp = (d != 0) ? int'(d) : k;
      exp_q.push_back({1'b0, exp_data, 16'(acc + exp_lat)});
      fab_result_i = ~res;
      for (int c = 1; c <= comp + 1; c++) begin
         @(negedge clk);
         if (c == 1 && !hold) cx_req_valid_i = 1'b0;
         chk("fab_start", {31'd0, fab_start_o}, {31'd0, (c == 1)});
         chk("ready_busy", {31'd0, cx_req_ready_o}, 32'd0);
         if (c == 1 || c == comp + 1) begin
            chk("fab_optype", {30'd0, fab_optype_o}, {30'd0, op});
            chk("fab_op_a", fab_operand_a_o, a);
            chk("fab_op_b", fab_operand_b_o, b);
         end
         if (tog) fab_done_i = c[0];
         else     fab_done_i = (d == 0) && (c == k);
         fab_result_i = (c == comp) ? res : ~res;
      end
      fab_done_i = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  d;
      logic [31:0] res;
      int          k;
      bit          tog;
      logic [31:0] exp_data;
      int          exp_lat;
   } vec_t;

   vec_t vecs[5];

   // ---------------- stimulus ----------------
   initial begin
      int acc;
      logic [3:0]  rd;
      logic [31:0] rr;
      logic [31:0] ra;
      logic [31:0] rb;

      vecs[0] = '{2'd1, 32'h0000_0003, 32'h0000_0004, 4'd3,  32'h0000_0007, 0, 1'b0, 32'h0000_0007, 4};
      vecs[1] = '{2'd2, 32'h1111_1111, 32'h2222_2222, 4'd0,  32'hCAFE_F00D, 5, 1'b0, 32'hCAFE_F00D, 6};
      vecs[2] = '{2'd3, 32'hDEAD_0001, 32'h0BAD_0002, 4'd15, 32'h0F0F_1234, 0, 1'b1, 32'h0F0F_1234, 16};
      vecs[3] = '{2'd0, 32'h0000_00AA, 32'h0000_0055, 4'd1,  32'hA5A5_A5A5, 0, 1'b0, 32'hA5A5_A5A5, 2};
      vecs[4] = '{2'd1, 32'h7777_0000, 32'h0000_8888, 4'd0,  32'h600D_BEEF, 1, 1'b0, 32'h600D_BEEF, 2};

      rst_n          = 1'b0;
      cx_req_valid_i = 1'b0;
      cx_optype_i    = '0;
      cx_operand_a_i = '0;
      cx_operand_b_i = '0;
      cx_delay_i     = '0;
      fab_result_i   = '0;
      fab_done_i     = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset state.
      chk("rst_ready", {31'd0, cx_req_ready_o}, 32'd1);
      chk("rst_resp_valid", {31'd0, cx_resp_valid_o}, 32'd0);
      chk("rst_resp_data", cx_resp_data_o, 32'd0);
      chk("rst_resp_err", {31'd0, cx_resp_err_o}, 32'd0);
      chk("rst_fab_start", {31'd0, fab_start_o}, 32'd0);
      chk("rst_fab_abort", {31'd0, fab_abort_o}, 32'd0);
      chk("rst_fab_optype", {30'd0, fab_optype_o}, 32'd0);
      chk("rst_fab_op_a", fab_operand_a_o, 32'd0);
      chk("rst_fab_op_b", fab_operand_b_o, 32'd0);

      // Table vectors.
      foreach (vecs[i]) begin
         run_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].res, vecs[i].k,
                 vecs[i].tog, 1'b0, vecs[i].exp_data, vecs[i].exp_lat);
      end

      // Response data holds between responses.
      repeat (3) @(negedge clk);
      chk("resp_data_hold", cx_resp_data_o, 32'h600D_BEEF);

      // Back-to-back: valid held through BUSY/RESP, second taken right after RESP.
      run_req(2'd2, 32'h0000_1000, 32'h0000_2000, 4'd1, 32'h1357_9BDF, 0, 1'b0, 1'b1,
              32'h1357_9BDF, 2);
      run_req(2'd3, 32'h0000_3000, 32'h0000_4000, 4'd1, 32'h2468_ACE0, 0, 1'b0, 1'b0,
              32'h2468_ACE0, 2);
      chk("b2b_no_wait", 32'(last_wait), 32'd0);

      // Random fixed-latency requests.
      for (int i = 0; i < 4; i++) begin
         rd = 4'($urandom_range(1, 8));
         rr = $urandom;
         ra = $urandom;
         rb = $urandom;
         run_req(2'($urandom_range(0, 3)), ra, rb, rd, rr, 0, 1'b0, 1'b0, rr, int'(rd) + 1);
      end

      // Reset during BUSY: no response, ready back, latched state cleared.
      offer(2'd1, 32'h0000_0ABC, 32'h0000_0DEF, 4'd10, acc);
      @(negedge clk);
      cx_req_valid_i = 1'b0;
      fab_result_i   = 32'hBADB_AD00;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_ready", {31'd0, cx_req_ready_o}, 32'd1);
      chk("midrst_resp_data", cx_resp_data_o, 32'd0);
      chk("midrst_fab_op_a", fab_operand_a_o, 32'd0);
      chk("midrst_abort", {31'd0, fab_abort_o}, 32'd0);
      repeat (15) @(negedge clk);
      run_req(2'd0, 32'h0000_0005, 32'h0000_0006, 4'd2, 32'h0000_0030, 0, 1'b0, 1'b0,
              32'h0000_0030, 3);

      // Zero delay with no done strobe.
      offer(2'd2, 32'h0000_0001, 32'h0000_0002, 4'd0, acc);
      fab_result_i = 32'hFFFF_FFFF;
`ifdef CX_TIMEOUT_EN
      exp_q.push_back({1'b1, 32'd0, 16'(acc + TMO + 1)});
      for (int c = 1; c <= TMO + 1; c++) begin
         @(negedge clk);
         if (c == 1) cx_req_valid_i = 1'b0;
         chk("tmo_ready", {31'd0, cx_req_ready_o}, 32'd0);
      end
`else
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (c == 1) cx_req_valid_i = 1'b0;
      end
      chk("no_tmo_still_busy", {31'd0, cx_req_ready_o}, 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
`endif
      repeat (4) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
